// File: rtl/acc_pkg.sv
// Shared widths, timeout default and FSM state encoding for the accumulator
// store unit.
package acc_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } st_state_t;

endpackage

// File: rtl/acc_store_unit_if.sv
// Memory write bus between the store unit (master) and the memory (slave).
interface acc_store_unit_if
    import acc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_ack;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_ack
    );

endinterface

// File: rtl/acc_st_timer.sv
// WRITE-phase cycle counter; expired flags the last cycle an ack may still
// arrive before the store is abandoned.
module acc_st_timer
    import acc_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of completed ack-less WRITE cycles
    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/acc_store_unit.sv
// Stores a captured accumulator value to memory, reporting done on ack or
// error after a bounded number of unacknowledged write cycles.
module acc_store_unit
    import acc_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] acc,
    input  logic              acc15,
    input  logic              accz,
    output logic              st_busy,
    output logic              st_done,
    output logic              st_err,
    output logic              st_n,
    output logic              st_z,
    acc_store_unit_if.master  mem
);

    st_state_t state;
    logic      accept;
    logic      in_write;
    logic      expired;

    assign accept   = (state == ST_IDLE) && st_req;
    assign in_write = (state == ST_WRITE);

    acc_st_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (in_write && !mem.mem_ack),
        .expired (expired)
    );

    // Address/data are driven from capture registers so the bus stays stable
    // for the whole write even if acc or st_addr move underneath it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_we    <= 1'b0;
            st_busy       <= 1'b0;
            st_done       <= 1'b0;
            st_err        <= 1'b0;
            st_n          <= 1'b0;
            st_z          <= 1'b0;
        end else begin
            st_done <= 1'b0;
            st_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (st_req) begin
                        state         <= ST_WRITE;
                        mem.mem_addr  <= st_addr;
                        mem.mem_wdata <= acc;
                        st_n          <= acc15;
                        st_z          <= accz;
                        mem.mem_we    <= 1'b1;
                        st_busy       <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // An ack in the final allowed cycle still counts as success
                    if (mem.mem_ack) begin
                        state      <= ST_DONE;
                        mem.mem_we <= 1'b0;
                        st_done    <= 1'b1;
                    end else if (expired) begin
                        state      <= ST_ERR;
                        mem.mem_we <= 1'b0;
                        st_err     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    st_busy <= 1'b0;
                end
                ST_ERR: begin
                    state   <= ST_IDLE;
                    st_busy <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    mem.mem_we <= 1'b0;
                    st_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
